// File: rtl/inst_fill_pkg.sv
// Shared definitions for the instruction-cache line refill engine.
//   fill_state_e : refill FSM states
//   LINE_*       : line geometry (4 x 32-bit words, 16-byte aligned)
//   line_base()  : clears the byte-in-line offset of an address
package inst_fill_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } fill_state_e;

  localparam int LINE_WORDS = 4;
  localparam int LINE_BITS  = 128;
  localparam int OFFSET_LSB = 2;
  localparam int OFFSET_MSB = 3;
  localparam int LINE_LSB   = 4;

  // Widest address line_base() handles; callers extend/truncate to their width.
  localparam int MAX_ADDR_W = 64;

  // Lines are always fetched in ascending order starting at word 0.
  localparam logic [OFFSET_MSB-OFFSET_LSB:0] START_WORD = '0;

  localparam logic [MAX_ADDR_W-1:0] LINE_MASK =
    ~((MAX_ADDR_W'(1) << LINE_LSB) - MAX_ADDR_W'(1));

  function automatic logic [MAX_ADDR_W-1:0] line_base(input logic [MAX_ADDR_W-1:0] addr);
    return addr & LINE_MASK;
  endfunction

endpackage

// File: rtl/inst_line_assembler.sv
// Line assembly register for the refill engine.
// Ports:
//   Clk   : clock
//   clr   : zero the whole line (start of a new fill or reset)
//   wr_en : write word into lane this cycle
//   lane  : 32-bit lane index 0..3
//   word  : word to write
//   line  : assembled line, word k in bits [32k+31:32k]
module inst_line_assembler
  import inst_fill_pkg::*;
(
  input  logic                 Clk,
  input  logic                 clr,
  input  logic                 wr_en,
  input  logic [1:0]           lane,
  input  logic [31:0]          word,
  output logic [LINE_BITS-1:0] line
);

  logic [LINE_BITS-1:0] line_q;
  logic [LINE_BITS-1:0] line_d;

  always_comb begin
    line_d = line_q;
    if (clr) begin
      line_d = '0;
    end else if (wr_en) begin
      line_d[{lane, 5'b00000} +: 32] = word;
    end
  end

  always_ff @(posedge Clk) begin
    line_q <= line_d;
  end

  assign line = line_q;

endmodule

// File: rtl/inst_line_fill.sv
// Instruction-cache line refill engine. On a miss, reads the 16-byte line
// holding miss_addr from a 32-bit memory one word per request/valid
// handshake, then presents the line to the cache as a one-cycle fill.
// Ports:
//   Clk, Reset_n          : clock, synchronous active-low reset
//   miss, miss_addr       : miss request and faulting byte address (IDLE only)
//   busy                  : engine is not IDLE
//   mem_rd, mem_addr      : one-cycle word read strobe and word address
//   mem_rdata, mem_valid  : read data and its valid
//   fill_valid            : one-cycle pulse, fill_addr/fill_data valid
//   fill_addr, fill_data  : line base address and line; held until next fill
//   fill_err              : line abandoned on memory timeout
// Build option:
//   INST_FILL_TIMEOUT_EN  : abandon the line after MAX_WAIT stalled WAIT
//                           cycles and pulse fill_err; otherwise WAIT stalls
//                           indefinitely and fill_err is 0.
module inst_line_fill
  import inst_fill_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int MAX_WAIT = 255
) (
  input  logic                 Clk,
  input  logic                 Reset_n,
  input  logic                 miss,
  input  logic [ADDR_W-1:0]    miss_addr,
  output logic                 busy,
  output logic                 mem_rd,
  output logic [ADDR_W-1:0]    mem_addr,
  input  logic [31:0]          mem_rdata,
  input  logic                 mem_valid,
  output logic                 fill_valid,
  output logic [ADDR_W-1:0]    fill_addr,
  output logic [LINE_BITS-1:0] fill_data,
  output logic                 fill_err
);

  localparam logic [1:0] LAST_BEAT = 2'(LINE_WORDS - 1);

  fill_state_e          state_q, state_d;
  logic [ADDR_W-1:0]    base_q, base_d;
  logic [1:0]           beat_q, beat_d;
  logic [ADDR_W-1:0]    fill_addr_q;
  logic [LINE_BITS-1:0] fill_data_q;
  logic [OFFSET_MSB-OFFSET_LSB:0] lane_w;
  logic                 asm_clr;
  logic                 asm_wr;
  logic [LINE_BITS-1:0] line_w;
  logic                 abort_w;

`ifdef INST_FILL_TIMEOUT_EN
  localparam int WCNT_W = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT);

  logic [WCNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              abort_q, abort_d;

  assign abort_w = abort_q;
`else
  localparam int unused_max_wait = MAX_WAIT;

  assign abort_w = 1'b0;
`endif

  // Lane index wraps mod 4 with the 2-bit beat counter.
  assign lane_w = START_WORD + beat_q;

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    beat_d  = beat_q;
    asm_clr = 1'b0;
    asm_wr  = 1'b0;
`ifdef INST_FILL_TIMEOUT_EN
    wait_cnt_d = wait_cnt_q;
    abort_d    = abort_q;
`endif
    case (state_q)
      IDLE: begin
        beat_d = '0;
`ifdef INST_FILL_TIMEOUT_EN
        abort_d = 1'b0;
`endif
        if (miss) begin
          base_d  = ADDR_W'(line_base(MAX_ADDR_W'(miss_addr)));
          asm_clr = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
`ifdef INST_FILL_TIMEOUT_EN
        wait_cnt_d = '0;
`endif
        state_d = WAIT;
      end
      WAIT: begin
        if (mem_valid) begin
          asm_wr = 1'b1;
          if (beat_q == LAST_BEAT) begin
            state_d = DONE;
          end else begin
            beat_d  = beat_q + 2'd1;
            state_d = REQ;
          end
        end
`ifdef INST_FILL_TIMEOUT_EN
        // This stalled cycle is the MAX_WAIT-th: give up on the line.
        else if (wait_cnt_q == WCNT_W'(MAX_WAIT - 1)) begin
          abort_d = 1'b1;
          state_d = DONE;
        end else begin
          wait_cnt_d = wait_cnt_q + WCNT_W'(1);
        end
`endif
      end
      DONE: begin
`ifdef INST_FILL_TIMEOUT_EN
        abort_d = 1'b0;
`endif
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Reset also drops any partially assembled line.
    if (!Reset_n) begin
      asm_clr = 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q     <= IDLE;
      base_q      <= '0;
      beat_q      <= '0;
      fill_addr_q <= '0;
      fill_data_q <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      beat_q  <= beat_d;
      if (fill_valid) begin
        fill_addr_q <= base_q;
        fill_data_q <= line_w;
      end
    end
  end

`ifdef INST_FILL_TIMEOUT_EN
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      wait_cnt_q <= '0;
      abort_q    <= 1'b0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      abort_q    <= abort_d;
    end
  end
`endif

  inst_line_assembler u_asm (
    .Clk   (Clk),
    .clr   (asm_clr),
    .wr_en (asm_wr),
    .lane  (lane_w),
    .word  (mem_rdata),
    .line  (line_w)
  );

  assign busy       = (state_q != IDLE);
  assign mem_rd     = (state_q == REQ);
  assign mem_addr   = mem_rd ? {base_q[ADDR_W-1:LINE_LSB], lane_w, 2'b00} : '0;
  assign fill_valid = (state_q == DONE) && !abort_w;
  assign fill_err   = (state_q == DONE) && abort_w;
  // The fill cycle shows the live line; afterwards the captured copy holds,
  // so an abandoned or in-progress line never disturbs the last good fill.
  assign fill_addr  = fill_valid ? base_q : fill_addr_q;
  assign fill_data  = fill_valid ? line_w : fill_data_q;

endmodule

// File: tb/tb_inst_line_fill.sv
module tb_inst_line_fill;

  localparam int ADDR_W = 32;

  logic               Clk = 1'b0;
  logic               Reset_n;
  logic               miss;
  logic [ADDR_W-1:0]  miss_addr;
  logic               busy;
  logic               mem_rd;
  logic [ADDR_W-1:0]  mem_addr;
  logic [31:0]        mem_rdata;
  logic               mem_valid;
  logic               fill_valid;
  logic [ADDR_W-1:0]  fill_addr;
  logic [127:0]       fill_data;
  logic               fill_err;

  inst_line_fill #(.ADDR_W(ADDR_W), .MAX_WAIT(8)) dut (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .miss       (miss),
    .miss_addr  (miss_addr),
    .busy       (busy),
    .mem_rd     (mem_rd),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata),
    .mem_valid  (mem_valid),
    .fill_valid (fill_valid),
    .fill_addr  (fill_addr),
    .fill_data  (fill_data),
    .fill_err   (fill_err)
  );

  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_mis = 0;

  // Memory model / monitor state
  int          mem_delay = 0;
  bit          spurious  = 1'b0;
  int          drop_idx  = 0;
  bit          pend      = 1'b0;
  int          pend_delay = 0;
  logic [31:0] pend_addr = '0;
  int          rd_cnt = 0;
  int          rd3_cyc = 0;
  logic [31:0] rd_addr[$];
  int          fv_cnt = 0;
  int          fv_cyc = 0;
  int          fe_cnt = 0;
  int          fe_cyc = 0;
  logic [31:0] fv_addr = '0;
  logic [127:0] fv_data = '0;

  task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_mis++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(negedge Clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_event(input string tag, input int bound);
    int start;
    int n;
    start = fv_cnt + fe_cnt;
    n = 0;
    while ((fv_cnt + fe_cnt) == start && n < bound) begin
      tick();
      n++;
    end
    check_val(tag, 128'((fv_cnt + fe_cnt) != start), 128'(1));
  endtask

  task automatic clear_mon();
    rd_cnt = 0;
    rd_addr.delete();
    fv_cnt = 0;
    fe_cnt = 0;
  endtask

  // Memory: answers each read mem_delay WAIT cycles late with 0xA0+addr,
  // optionally injecting a junk valid during the REQ cycle or dropping a read.
  initial begin
    mem_valid = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge Clk);
      mem_valid = 1'b0;
      mem_rdata = '0;
      if (pend) begin
        if (pend_delay == 0) begin
          mem_valid = 1'b1;
          mem_rdata = pend_addr + 32'hA0;
          pend = 1'b0;
        end else begin
          pend_delay--;
        end
      end
      if (mem_rd === 1'b1) begin
        rd_cnt++;
        rd_addr.push_back(mem_addr);
        if (rd_cnt == 3) rd3_cyc = cyc;
        if (rd_cnt != drop_idx) begin
          pend = 1'b1;
          pend_addr = mem_addr;
          pend_delay = mem_delay;
        end
        if (spurious) begin
          mem_valid = 1'b1;
          mem_rdata = 32'hDEADBEEF;
        end
      end
      if (fill_valid === 1'b1) begin
        fv_cnt++;
        fv_cyc = cyc;
        fv_addr = fill_addr;
        fv_data = fill_data;
      end
      if (fill_err === 1'b1) begin
        fe_cnt++;
        fe_cyc = cyc;
      end
    end
  end

  initial begin
    int c0;
    Reset_n = 1'b0;
    miss = 1'b0;
    miss_addr = '0;
    ticks(3);
    Reset_n = 1'b1;
    tick();

    check_val("rst_busy",       128'(busy),       128'(0));
    check_val("rst_mem_rd",     128'(mem_rd),     128'(0));
    check_val("rst_mem_addr",   128'(mem_addr),   128'(0));
    check_val("rst_fill_valid", 128'(fill_valid), 128'(0));
    check_val("rst_fill_addr",  128'(fill_addr),  128'(0));
    check_val("rst_fill_data",  fill_data,        128'(0));
    check_val("rst_fill_err",   128'(fill_err),   128'(0));

    // Reset while WAIT is stalled
    mem_delay = 20;
    miss_addr = 32'h48;
    miss = 1'b1;
    tick();
    miss = 1'b0;
    tick();
    check_val("midrst_busy_before", 128'(busy), 128'(1));
    Reset_n = 1'b0;
    ticks(2);
    Reset_n = 1'b1;
    tick();
    check_val("midrst_busy",       128'(busy),       128'(0));
    check_val("midrst_fill_valid", 128'(fill_valid), 128'(0));
    check_val("midrst_mem_addr",   128'(mem_addr),   128'(0));
    ticks(30);
    check_val("midrst_no_fill",    128'(fv_cnt),     128'(0));
    check_val("midrst_fill_data",  fill_data,        128'(0));
    check_val("midrst_idle",       128'(busy),       128'(0));

    // Single-cycle memory, miss at 0x48
    clear_mon();
    mem_delay = 0;
    miss_addr = 32'h48;
    miss = 1'b1;
    c0 = cyc;
    tick();
    miss = 1'b0;
    wait_event("t1_fill_seen", 50);
    check_val("t1_latency", 128'(fv_cyc - c0 + 1), 128'(10));
    check_val("t1_rd_cnt", 128'(rd_cnt), 128'(4));
    for (int i = 0; i < 4; i++)
      check_val($sformatf("t1_mem_addr%0d", i), 128'(rd_addr[i]), 128'(32'h40 + 4 * i));
    check_val("t1_fill_addr", 128'(fv_addr), 128'(32'h40));
    check_val("t1_fill_data", fv_data, {32'hEC, 32'hE8, 32'hE4, 32'hE0});
    tick();
    check_val("t1_fv_pulse", 128'(fill_valid), 128'(0));
    check_val("t1_busy_after", 128'(busy), 128'(0));
    ticks(3);
    check_val("t1_hold_data", fill_data, {32'hEC, 32'hE8, 32'hE4, 32'hE0});
    check_val("t1_hold_addr", 128'(fill_addr), 128'(32'h40));

    // Slow memory, junk valid during REQ, miss held high through the fill
    clear_mon();
    mem_delay = 3;
    spurious = 1'b1;
    miss_addr = 32'h100;
    miss = 1'b1;
    c0 = cyc;
    wait_event("t2_fill_seen", 100);
    miss = 1'b0;
    spurious = 1'b0;
    check_val("t2_latency", 128'(fv_cyc - c0 + 1), 128'(22));
    ticks(20);
    check_val("t2_rd_cnt", 128'(rd_cnt), 128'(4));
    check_val("t2_fv_cnt", 128'(fv_cnt), 128'(1));
    check_val("t2_fill_addr", 128'(fv_addr), 128'(32'h100));
    check_val("t2_fill_data", fv_data, {32'h1AC, 32'h1A8, 32'h1A4, 32'h1A0});
    check_val("t2_busy_after", 128'(busy), 128'(0));

    // Miss during an active fill is dropped; reasserted miss is served
    clear_mon();
    mem_delay = 0;
    miss_addr = 32'h200;
    miss = 1'b1;
    tick();
    miss = 1'b0;
    ticks(2);
    miss_addr = 32'h1234;
    miss = 1'b1;
    ticks(2);
    miss = 1'b0;
    wait_event("t3_fill_seen", 50);
    check_val("t3_fill_addr", 128'(fv_addr), 128'(32'h200));
    check_val("t3_fill_data", fv_data, {32'h2AC, 32'h2A8, 32'h2A4, 32'h2A0});
    ticks(8);
    check_val("t3_no_second", 128'(fv_cnt), 128'(1));
    check_val("t3_rd_cnt", 128'(rd_cnt), 128'(4));
    check_val("t3_idle", 128'(busy), 128'(0));
    miss_addr = 32'h1234;
    miss = 1'b1;
    tick();
    miss = 1'b0;
    wait_event("t3_refill_seen", 50);
    check_val("t3_refill_addr", 128'(fv_addr), 128'(32'h1230));
    check_val("t3_refill_data", fv_data, {32'h12DC, 32'h12D8, 32'h12D4, 32'h12D0});
    check_val("t3_fv_cnt", 128'(fv_cnt), 128'(2));
    ticks(3);

    // Memory never answers the third read (beat 2)
    clear_mon();
    drop_idx = 3;
    miss_addr = 32'h300;
    miss = 1'b1;
    tick();
    miss = 1'b0;
`ifdef INST_FILL_TIMEOUT_EN
    wait_event("t4_err_seen", 60);
    check_val("t4_fe_cnt", 128'(fe_cnt), 128'(1));
    check_val("t4_fv_cnt", 128'(fv_cnt), 128'(0));
    check_val("t4_wait_cycles", 128'(fe_cyc - rd3_cyc), 128'(9));
    check_val("t4_err_out", 128'(fill_err), 128'(1));
    check_val("t4_fv_out", 128'(fill_valid), 128'(0));
    check_val("t4_held_data", fill_data, {32'h12DC, 32'h12D8, 32'h12D4, 32'h12D0});
    tick();
    check_val("t4_busy_after", 128'(busy), 128'(0));
    check_val("t4_err_pulse", 128'(fill_err), 128'(0));
    check_val("t4_held_addr", 128'(fill_addr), 128'(32'h1230));
`else
    ticks(60);
    check_val("t4_still_busy", 128'(busy), 128'(1));
    check_val("t4_fe_cnt", 128'(fe_cnt), 128'(0));
    check_val("t4_fv_cnt", 128'(fv_cnt), 128'(0));
    check_val("t4_err_out", 128'(fill_err), 128'(0));
    check_val("t4_rd_cnt", 128'(rd_cnt), 128'(3));
    Reset_n = 1'b0;
    ticks(2);
    Reset_n = 1'b1;
    tick();
    check_val("t4_busy_after_rst", 128'(busy), 128'(0));
`endif
    drop_idx = 0;
    ticks(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/inst_line_fill.md
Name: inst_line_fill

Overview:
Refill engine on the far side of the instruction cache. On a cache miss it fetches the 128-bit line containing the missed address from a 32-bit word-wide instruction memory, one word per handshake. It then delivers the assembled line to the cache as a single-cycle fill write. It sits between the cache miss signal and main instruction memory, and sources the cache's line-data and line-address inputs.

Parameters:
ADDR_W, 32, byte-address width of miss and memory addresses
MAX_WAIT, 255, cycles WAIT may stall on mem_valid before the beat is abandoned (only with INST_FILL_TIMEOUT_EN)

Ports:
Clk  in  1  system clock, all state updates on rising edge
Reset_n  in  1  synchronous active-low reset
miss  in  1  cache miss request, sampled only in IDLE
miss_addr  in  ADDR_W  faulting instruction byte address
busy  out  1  high in every state except IDLE
mem_rd  out  1  single-cycle word read strobe to memory
mem_addr  out  ADDR_W  word-aligned read address, valid while mem_rd=1
mem_rdata  in  32  read data, valid with mem_valid
mem_valid  in  1  read-data-valid from memory
fill_valid  out  1  single-cycle pulse: fill_data/fill_addr are valid
fill_addr  out  ADDR_W  line-aligned base address {miss_addr[ADDR_W-1:4],4'b0}
fill_data  out  128  assembled line; word k occupies bits [32k+31:32k]
fill_err  out  1  line abandoned (timeout build only; constant 0 otherwise)

Behaviour:
- Clock is Clk; reset is synchronous, active-low on Reset_n. Reset dominates all other inputs.
- Reset values: state IDLE, busy=0, mem_rd=0, mem_addr=0, fill_valid=0, fill_addr=0, fill_data=0, fill_err=0, beat counter=0.
- States: IDLE, REQ, WAIT, DONE.
- IDLE:
  - If miss=1, latch base={miss_addr[ADDR_W-1:4],4'b0} and start word s=0.
  - Clear the beat count; next state is REQ.
- REQ:
  - mem_rd=1 for exactly one cycle, with mem_addr=base+4*w, where w=(s+beat) mod 4.
  - Next state is WAIT.
- WAIT:
  - mem_rd=0. On mem_valid=1, write mem_rdata into lane w.
  - If beat==3, go to DONE; otherwise increment beat and go to REQ.
  - mem_valid in the same cycle as the REQ strobe is not accepted; the earliest accept is the cycle after REQ.
- DONE:
  - fill_valid=1 for one cycle, with fill_addr=base and fill_data=the full line.
  - Next state is IDLE. fill_data and fill_addr hold until the next fill.
- Latency with single-cycle memory: 1 (IDLE) + 4×(REQ+WAIT) + 1 (DONE) = 10 cycles from miss sampled to fill_valid.
- miss asserted while busy=1 is ignored; no queueing. The cache re-asserts after the fill.
- mem_valid outside WAIT is ignored and does not change the line.
- Reset mid-line discards partial data and does not assert fill_valid.
- The beat counter is 2 bits and wraps 3→0; w lane index computed mod 4.

Optional Feature:
Macro INST_FILL_TIMEOUT_EN.
- Defined:
  - A wait counter clears on entry to WAIT and increments each WAIT cycle without mem_valid.
  - When it reaches MAX_WAIT, go to DONE with fill_valid=0 and fill_err=1 for one cycle, then return to IDLE. Partial data is discarded.
- Not defined: WAIT stalls indefinitely and fill_err is tied to 0.
- Independent of the timeout: a critical-word-first variant (s=miss_addr[3:2]) is not part of this block.

Decomposition:
- Package inst_fill_pkg:
  - state enum {IDLE,REQ,WAIT,DONE}
  - LINE_WORDS=4, LINE_BITS=128
  - OFFSET_LSB=2, OFFSET_MSB=3, LINE_LSB=4
  - function line_base(addr)
- Sub-module inst_line_assembler holds the lane register and lane-write enable:
  - inputs: clr, wr_en, lane[1:0], word[31:0]
  - output: line[127:0]
- The FSM, counters and handshake stay in inst_line_fill.

Test Plan:
- Reset_n=0 for 2 cycles mid-WAIT, then release → all outputs 0, state IDLE, no fill_valid.
- miss=1, miss_addr=0x0000_0048, memory returns 0xA0+addr on the cycle after each mem_rd:
  - mem_addr sequence 0x40,0x44,0x48,0x4C
  - fill_valid at cycle 10 with fill_addr=0x40 and fill_data=0x...EC_E8_E4_E0 in the correct lanes.
- Memory delays mem_valid 3 cycles per beat, with miss held high and spurious mem_valid pulses during REQ → exactly 4 mem_rd pulses, line unchanged by spurious data, one fill_valid.
- Second miss (addr 0x1234) asserted during an active fill → ignored. After fill_valid and reassertion, a new fill starts with fill_addr=0x1230.
- INST_FILL_TIMEOUT_EN, MAX_WAIT=8, memory never responds on beat 2 → fill_err pulses after 8 WAIT cycles, fill_valid stays 0, busy=0 next cycle. Without the macro, busy remains 1.
